instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 112 +++++++++++
 tb/tb_instr_fetch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one-word fetch for ordinary opcodes, two-word fetch for LDM,
// presenting one instruction at a time to decode under a valid/ready handshake.
module instr_fetch #(
    parameter int               width    = 16,
    parameter logic [width-1:0] RESET_PC = '0,
    parameter logic [4:0]       LDM_OP   = 5'b10100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             redirect,
    input  logic [width-1:0] redirect_pc,
    output logic             imem_en,
    output logic [width-1:0] imem_addr,
    input  logic [width-1:0] imem_rdata,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [width-1:0] instr_out,
    output logic [width-1:0] imm_out,
    output logic             ldm_out,
    output logic [width-1:0] pc_out
);

    // Handshake: a transfer happens on a rising edge where out_valid, out_ready and
    // enable are all 1; out_valid never depends on out_ready, and data holds until then.

    typedef enum logic [2:0] {
        REQ_OP  = 3'd0,
        RSP_OP  = 3'd1,
        REQ_IMM = 3'd2,
        RSP_IMM = 3'd3,
        OUT     = 3'd4
    } state_t;

    localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic [width-1:0] pc;
    logic             is_ldm;

    assign is_ldm = (imem_rdata[width-1 -: 5] == LDM_OP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ_OP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (enable) begin
            if (redirect) begin
                state_next = REQ_OP;
            end else begin
                case (state)
                    REQ_OP:  state_next = RSP_OP;
                    RSP_OP:  state_next = is_ldm ? REQ_IMM : OUT;
                    REQ_IMM: state_next = RSP_IMM;
                    RSP_IMM: state_next = OUT;
                    OUT:     state_next = out_ready ? REQ_OP : OUT;
                    default: state_next = REQ_OP;
                endcase
            end
        end
    end

    always_comb begin
        imem_en   = 1'b0;
        imem_addr = pc;
        out_valid = (state == OUT);
        if (!rst && enable && (state == REQ_OP || state == REQ_IMM)) begin
            imem_en = 1'b1;
        end
    end

    // pc already points past the word in flight, so the opcode's address is pc - 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            instr_out <= '0;
            imm_out   <= '0;
            ldm_out   <= 1'b0;
            pc_out    <= '0;
        end else if (enable) begin
            if (redirect) begin
                pc <= redirect_pc;
            end else begin
                case (state)
                    REQ_OP, REQ_IMM: begin
                        pc <= pc + ONE;
                    end
                    RSP_OP: begin
                        instr_out <= imem_rdata;
                        pc_out    <= pc - ONE;
                        imm_out   <= '0;
                        ldm_out   <= 1'b0;
                    end
                    RSP_IMM: begin
                        imm_out <= imem_rdata;
                        ldm_out <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle-vector table, directed corner sequences, then
// random traffic scored against a program-order model of the instruction stream.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        rst_w;
    logic        enable;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_ready;

    logic        imem_en,   imem_en_w;
    logic [15:0] imem_addr, imem_addr_w;
    logic [15:0] imem_rdata, imem_rdata_w;
    logic        out_valid, out_valid_w;
    logic [15:0] instr_out, instr_out_w;
    logic [15:0] imm_out,   imm_out_w;
    logic        ldm_out,   ldm_out_w;
    logic [15:0] pc_out,    pc_out_w;

    logic [15:0] mem [0:65535];

    int total;
    int bad;

    localparam logic [4:0] LDM = 5'b10100;

    instr_fetch #(.width(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .out_ready(out_ready), .out_valid(out_valid),
        .instr_out(instr_out), .imm_out(imm_out), .ldm_out(ldm_out), .pc_out(pc_out)
    );

    instr_fetch #(.width(16), .RESET_PC(16'hFFFF)) dut_w (
        .clk(clk), .rst(rst_w), .enable(enable), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_en(imem_en_w), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .out_ready(out_ready), .out_valid(out_valid_w),
        .instr_out(instr_out_w), .imm_out(imm_out_w), .ldm_out(ldm_out_w), .pc_out(pc_out_w)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    // Synchronous memory: data appears the cycle after a strobe and holds until the next one.
    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= mem[imem_addr];
        if (imem_en_w) imem_rdata_w <= mem[imem_addr_w];
    end

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic sel, input logic exp_en,
                             input logic [15:0] exp_addr, input logic exp_valid);
        check({tag, ".imem_en"}, 16'(sel ? imem_en_w : imem_en), 16'(exp_en));
        if (exp_en) check({tag, ".imem_addr"}, sel ? imem_addr_w : imem_addr, exp_addr);
        check({tag, ".out_valid"}, 16'(sel ? out_valid_w : out_valid), 16'(exp_valid));
    endtask

    task automatic chk_data(input string tag, input logic sel, input logic [15:0] ei,
                            input logic [15:0] em, input logic el, input logic [15:0] ep);
        check({tag, ".instr_out"}, sel ? instr_out_w : instr_out, ei);
        check({tag, ".imm_out"}, sel ? imm_out_w : imm_out, em);
        check({tag, ".ldm_out"}, 16'(sel ? ldm_out_w : ldm_out), 16'(el));
        check({tag, ".pc_out"}, sel ? pc_out_w : pc_out, ep);
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        rst;
        logic        en;
        logic        ready;
        logic        chk;
        logic        exp_en;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic        chk_data;
        logic [15:0] exp_instr;
        logic [15:0] exp_imm;
        logic        exp_ldm;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs [10];

    // model state for the random phase
    logic [15:0] model_pc;
    logic [15:0] e_instr, e_imm, e_pc, nxt;
    logic        e_ldm;
    logic        hs, hold_pend;
    logic [15:0] h_instr, h_imm, h_pc;
    logic        h_ldm;
    int          hs_count;
    int          idle;

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; rst_w = 1'b1; enable = 1'b1; redirect = 1'b0;
        redirect_pc = 16'h0000; out_ready = 1'b1;
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        mem[0]     = 16'h1234;
        mem[1]     = 16'hA255;
        mem[2]     = 16'h00FF;
        mem[3]     = 16'h5678;
        mem[4]     = 16'h1111;
        mem[16'h40] = 16'h2222;
        mem[16'h41] = 16'hA230;
        mem[16'h42] = 16'hBEEF;
        mem[16'hFFFF] = 16'hA200;

        //          rst   en    rdy   chk   en?   addr      vld   chkd  instr     imm       ldm   pc
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b0, 16'h0000};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hA255, 16'h00FF, 1'b1, 16'h0001};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};

        for (int i = 0; i < 10; i++) begin
            rst = vecs[i].rst; enable = vecs[i].en; out_ready = vecs[i].ready;
            #1;
            if (vecs[i].chk) chk_fetch($sformatf("vec%0d", i), 1'b0, vecs[i].exp_en,
                                       vecs[i].exp_addr, vecs[i].exp_valid);
            if (vecs[i].chk_data) chk_data($sformatf("vec%0d", i), 1'b0, vecs[i].exp_instr,
                                           vecs[i].exp_imm, vecs[i].exp_ldm, vecs[i].exp_pc);
            next_cyc();
        end

        // ---- stall in OUT for 5 cycles, then release ----
        out_ready = 1'b0;
        #1 chk_fetch("stall_rsp", 1'b0, 1'b0, 16'h0, 1'b0);
        next_cyc();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_fetch($sformatf("stall%0d", i), 1'b0, 1'b0, 16'h0, 1'b1);
            chk_data($sformatf("stall%0d", i), 1'b0, 16'h5678, 16'h0000, 1'b0, 16'h0003);
            next_cyc();
        end
        out_ready = 1'b1;
        #1 chk_fetch("release", 1'b0, 1'b0, 16'h0, 1'b1);
        next_cyc();
        #1 chk_fetch("after_release", 1'b0, 1'b1, 16'h0004, 1'b0);
        next_cyc();

        // ---- redirect while the word is in RSP_OP ----
        redirect = 1'b1; redirect_pc = 16'h0040;
        #1 chk_fetch("redir_rsp", 1'b0, 1'b0, 16'h0, 1'b0);
        next_cyc();
        redirect = 1'b0;
        #1 chk_fetch("redir_req", 1'b0, 1'b1, 16'h0040, 1'b0);
        next_cyc();
        #1 chk_fetch("redir_wait", 1'b0, 1'b0, 16'h0, 1'b0);
        next_cyc();
        #1 chk_fetch("redir_out", 1'b0, 1'b0, 16'h0, 1'b1);
        chk_data("redir_out", 1'b0, 16'h2222, 16'h0000, 1'b0, 16'h0040);
        next_cyc();

        // ---- LDM with enable low for 3 cycles in RSP_IMM ----
        #1 chk_fetch("ldm_op", 1'b0, 1'b1, 16'h0041, 1'b0);
        next_cyc(); next_cyc();
        #1 chk_fetch("ldm_imm", 1'b0, 1'b1, 16'h0042, 1'b0);
        next_cyc();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk_fetch($sformatf("frozen%0d", i), 1'b0, 1'b0, 16'h0, 1'b0);
            next_cyc();
        end
        enable = 1'b1;
        #1 chk_fetch("thaw", 1'b0, 1'b0, 16'h0, 1'b0);
        next_cyc();
        #1 chk_fetch("ldm_out", 1'b0, 1'b0, 16'h0, 1'b1);
        chk_data("ldm_out", 1'b0, 16'hA230, 16'hBEEF, 1'b1, 16'h0041);
        next_cyc();
        #1 chk_fetch("ldm_next", 1'b0, 1'b1, 16'h0043, 1'b0);
        next_cyc();

        // ---- RESET_PC=FFFF instance: wrap of the immediate, reset in RSP_OP ----
        rst_w = 1'b0;
        #1 chk_fetch("wrap_op", 1'b1, 1'b1, 16'hFFFF, 1'b0);
        next_cyc(); next_cyc();
        #1 chk_fetch("wrap_imm", 1'b1, 1'b1, 16'h0000, 1'b0);
        next_cyc(); next_cyc();
        #1 chk_fetch("wrap_out", 1'b1, 1'b0, 16'h0, 1'b1);
        chk_data("wrap_out", 1'b1, 16'hA200, 16'h1234, 1'b1, 16'hFFFF);
        next_cyc();
        #1 chk_fetch("wrap_next", 1'b1, 1'b1, 16'h0001, 1'b0);
        next_cyc();
        rst_w = 1'b1;
        next_cyc();
        rst_w = 1'b0;
        #1 chk_fetch("rst_mid", 1'b1, 1'b1, 16'hFFFF, 1'b0);
        chk_data("rst_mid", 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        next_cyc(); next_cyc();
        #1 chk_fetch("rst_mid_imm", 1'b1, 1'b1, 16'h0000, 1'b0);
        rst_w = 1'b1;

        // ---- random traffic against the program-order model ----
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 9) < 3) mem[a][15:11] = LDM;
        end
        model_pc  = 16'h0000;
        hold_pend = 1'b0;
        hs_count  = 0;
        idle      = 0;
        for (int c = 0; c < 4000; c++) begin
            next_cyc();
            rst         = (c == 0) || ($urandom_range(0, 199) == 0);
            enable      = ($urandom_range(0, 99) < 85);
            out_ready   = ($urandom_range(0, 99) < 65);
            redirect    = ($urandom_range(0, 99) < 4);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                                      : 16'($urandom_range(0, 65535));
            #1;
            if (hold_pend) begin
                check("hold.out_valid", 16'(out_valid), 16'h0001);
                chk_data("hold", 1'b0, h_instr, h_imm, h_ldm, h_pc);
            end
            hs = !rst && enable && out_valid && out_ready;
            if (hs) begin
                e_instr = mem[model_pc];
                e_ldm   = (e_instr[15:11] == LDM);
                nxt     = model_pc + 16'd1;
                e_imm   = e_ldm ? mem[nxt] : 16'h0000;
                e_pc    = model_pc;
                chk_data($sformatf("rand%0d", hs_count), 1'b0, e_instr, e_imm, e_ldm, e_pc);
                model_pc = model_pc + (e_ldm ? 16'd2 : 16'd1);
                hs_count++;
                idle = 0;
            end else begin
                idle++;
            end
            if (rst) model_pc = 16'h0000;
            else if (enable && redirect) model_pc = redirect_pc;
            hold_pend = !rst && out_valid && !(enable && (redirect || out_ready));
            h_instr = instr_out; h_imm = imm_out; h_ldm = ldm_out; h_pc = pc_out;
            if (idle > 300) begin
                total++;
                bad++;
                $display("FAIL watchdog: got %0d idle cycles want at most 300", idle);
                break;
            end
        end
        check("enough_handshakes", 16'(hs_count >= 100), 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
